full_adder_reg: RTL and testbench

- Registered full adder: adds operands a and b plus carry-in c, producing sum and carry-out.
- Built as a ripple chain of 1-bit full-adder cells, followed by a single output register stage with a valid flag.
- Used as the basic arithmetic cell in datapaths. With WIDTH=1 it is a classic 1-bit full adder delayed by one clock.

---
 rtl/full_adder_reg_if.sv | 22 ++
 rtl/full_adder_reg.sv | 41 ++++
 tb/tb_full_adder_reg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/full_adder_reg_if.sv
// rtl/full_adder_reg_if.sv - operand/result bundle for the registered full adder
interface full_adder_reg_if #(
   parameter int WIDTH = 1
) ();
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             out_valid;

   modport master (
      output in_valid, a, b, c,
      input  sum, carry, out_valid
   );

   modport slave (
      input  in_valid, a, b, c,
      output sum, carry, out_valid
   );
endinterface

// File: rtl/full_adder_reg.sv
// rtl/full_adder_reg.sv - ripple-carry full adder with one registered output stage
module full_adder_reg #(
   parameter int WIDTH = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   full_adder_reg_if.slave bus
);
   logic [WIDTH:0]   w_k;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_valid;

   assign w_k[0] = bus.c;

   // Ripple chain of 1-bit cells; carry k propagates LSB to MSB.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign w_s[i]   = bus.a[i] ^ bus.b[i] ^ w_k[i];
      assign w_k[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & w_k[i]) | (bus.b[i] & w_k[i]);
   end

   // Output stage: reset wins, valid loads the result, otherwise hold data and drop valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_valid <= 1'b0;
      end else if (bus.in_valid) begin
         r_sum   <= w_s;
         r_carry <= w_k[WIDTH];
         r_valid <= 1'b1;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign bus.sum       = r_sum;
   assign bus.carry     = r_carry;
   assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_full_adder_reg.sv
// tb/tb_full_adder_reg.sv - directed and random checks of full_adder_reg at WIDTH 1 and 8
module tb_full_adder_reg;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   full_adder_reg_if #(.WIDTH(1)) bus1 ();
   full_adder_reg_if #(.WIDTH(8)) bus8 ();

   full_adder_reg #(.WIDTH(1)) u_dut1 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus1.slave)
   );

   full_adder_reg #(.WIDTH(8)) u_dut8 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] tt_exp [8];
   logic [8:0] exp9;
   logic [2:0] abc;

   initial begin
      n_checks = 0;
      n_errors = 0;
      tt_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

      rst = 1'b1;
      bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b1;
      bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c = 1'b1;

      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_sum1",   64'(bus1.sum),       64'h0);
         check("rst_carry1", 64'(bus1.carry),     64'h0);
         check("rst_valid1", 64'(bus1.out_valid), 64'h0);
         check("rst_sum8",   64'(bus8.sum),       64'h0);
         check("rst_valid8", 64'(bus8.out_valid), 64'h0);
      end

      rst = 1'b0;
      bus8.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         abc = 3'(i);
         bus1.in_valid = 1'b1;
         bus1.a = abc[2]; bus1.b = abc[1]; bus1.c = abc[0];
         step();
         check("tt_sum_carry", 64'({bus1.sum, bus1.carry}), 64'(tt_exp[i]));
         check("tt_valid",     64'(bus1.out_valid),         64'h1);
      end

      bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0;
      step();
      check("hold_sum",   64'(bus1.sum),       64'h1);
      check("hold_carry", 64'(bus1.carry),     64'h1);
      check("hold_valid", 64'(bus1.out_valid), 64'h0);

      rst = 1'b1;
      bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b1;
      step();
      check("prio_sum",   64'(bus1.sum),       64'h0);
      check("prio_carry", 64'(bus1.carry),     64'h0);
      check("prio_valid", 64'(bus1.out_valid), 64'h0);
      rst = 1'b0;
      step();
      check("rel_sum",   64'(bus1.sum),       64'h0);
      check("rel_carry", 64'(bus1.carry),     64'h1);
      check("rel_valid", 64'(bus1.out_valid), 64'h1);
      bus1.in_valid = 1'b0;

      bus8.in_valid = 1'b1;
      bus8.a = 8'hFF; bus8.b = 8'h01; bus8.c = 1'b0;
      step();
      check("w8_ff_01",  64'({bus8.carry, bus8.sum}), 64'h100);
      check("w8_valid",  64'(bus8.out_valid),         64'h1);
      bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c = 1'b1;
      step();
      check("w8_ff_ff_1", 64'({bus8.carry, bus8.sum}), 64'h1FF);
      bus8.a = 8'h12; bus8.b = 8'h34; bus8.c = 1'b1;
      step();
      check("w8_12_34_1", 64'({bus8.carry, bus8.sum}), 64'h047);
      bus8.a = 8'h00; bus8.b = 8'h00; bus8.c = 1'b0;
      step();
      check("w8_zero", 64'({bus8.carry, bus8.sum}), 64'h000);

      for (int i = 0; i < 1000; i++) begin
         bus8.a = 8'($urandom_range(0, 255));
         bus8.b = 8'($urandom_range(0, 255));
         bus8.c = 1'($urandom_range(0, 1));
         exp9 = {1'b0, bus8.a} + {1'b0, bus8.b} + {8'h00, bus8.c};
         step();
         check("w8_rand", 64'({bus8.carry, bus8.sum, bus8.out_valid}), 64'({exp9, 1'b1}));
      end

      bus8.in_valid = 1'b0;
      step();
      check("w8_idle_valid", 64'(bus8.out_valid), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
